// File: rtl/uart_pkg.sv
// Shared UART constants and helpers: default byte width, baud divider, FIFO pointer width.
// No logic; purely compile-time values.
// No backpressure; not a datapath element.
package uart_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CLK_HZ = 27_000_000;
    localparam int BAUD = 115_200;
    localparam int DELAY_FRAMES = CLK_HZ / BAUD;

    // One extra bit beyond the index distinguishes full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic pointer/array FIFO with show-ahead head data, full/empty/level status.
// Latency: a write is visible at the head one cycle later; no write-to-read bypass.
// Backpressure: push ignored when full unless a pop happens the same cycle.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = DATA_W_DEF,
    localparam int PW    = ptr_w(DEPTH),
    localparam int AW    = PW - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop,
    output logic [DATA_W-1:0] head_dat,
    output logic              full,
    output logic              empty,
    output logic [PW-1:0]     level
);

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_en;
    logic              rd_en;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level    = wr_ptr_q - rd_ptr_q;
    assign rd_en    = pop & ~empty;
    assign wr_en    = push & (~full | rd_en);
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive byte buffer: edge-captures rx_byte_ready into a FIFO, valid/ready output, sticky overflow.
// Latency: byte visible one cycle after the sampled rising edge; pop advances head next cycle.
// Backpressure: drops and flags bytes when full; UART_RX_FIFO_DROP_COUNT_EN adds a saturating drop_count.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     rx_byte_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clear_overflow
`ifdef UART_RX_FIFO_DROP_COUNT_EN
    ,
    output logic [7:0]               drop_count
`endif
);

    logic              rdy_q;
    logic              overflow_q, overflow_d;
    logic              push;
    logic              pop;
    logic              drop;
    logic [DATA_W-1:0] head_dat;

    // Reset value 1 so a level already high at reset release is not taken as a new byte.
    assign push      = rx_byte_ready & ~rdy_q;
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign drop      = push & full & ~pop;
    assign out_data  = empty ? '0 : head_dat;
    assign overflow  = overflow_q;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (rx_data),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    always_comb begin
        overflow_d = overflow_q;
        if (clear_overflow) overflow_d = 1'b0;
        if (drop)           overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q      <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            rdy_q      <= rx_byte_ready;
            overflow_q <= overflow_d;
        end
    end

`ifdef UART_RX_FIFO_DROP_COUNT_EN
    logic [7:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop) begin
            if (clear_overflow)             drop_count_d = 8'd1;
            else if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
        end else if (clear_overflow) begin
            drop_count_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_count_q <= 8'd0;
        else        drop_count_q <= drop_count_d;
    end

    assign drop_count = drop_count_q;
`endif

endmodule
